path_sequencer: RTL and testbench

PATH_SEQUENCER -- requirements
Module: path_sequencer

---
 rtl/path_sequencer.sv | 169 ++++++++++++++++
 tb/tb_path_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/path_sequencer.sv
// Path sequencer: collects a node path from the planner, loads it into the
// path mapper, then walks it segment by segment, turning each node-detect
// edge into a segment-advance pulse and a handshaked turn command.
module path_sequencer #(
  parameter int MAX_NODES = 6,
  parameter int TURN_LAT  = 8
) (
  input  logic       clk_3125KHz,
  input  logic       rst_n,
  input  logic       start,
  input  logic       path_valid,
  input  logic [4:0] path_node,
  input  logic       path_last,
  output logic       path_ready,
  input  logic       node_flag,
  input  logic [1:0] turn_flag,
  output logic       path_input,
  output logic [4:0] path_planned,
  output logic       node_changed,
  output logic       turn_valid,
  output logic [1:0] turn_cmd,
  input  logic       turn_ready,
  output logic [2:0] seg_idx,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int PTR_W = $clog2(MAX_NODES + 1);
  localparam int LAT_W = (TURN_LAT > 1) ? $clog2(TURN_LAT) : 1;

  typedef enum logic [3:0] {
    IDLE, COLLECT, LOAD, WAIT_NODE, KICK, SETTLE, ISSUE, DONE, ERR
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] wr;
  logic [PTR_W-1:0] rd;
  logic [PTR_W-1:0] node_total;
  logic [LAT_W-1:0] settle;
  logic             nf_p0;
  logic             node_rise;
  logic [2:0]       seg_nxt;
  logic [4:0]       buffer [MAX_NODES];

  assign node_rise = node_flag & ~nf_p0;
  assign seg_nxt   = seg_idx + 3'd1;

  // Path buffer: written on every accepted planner node, never reset.
  always_ff @(posedge clk_3125KHz) begin
    if (state == COLLECT && path_valid)
      buffer[wr] <= path_node;
  end

  // node_flag history for rising-edge detection.
  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) nf_p0 <= 1'b0;
    else        nf_p0 <= node_flag;
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wr           <= '0;
      rd           <= '0;
      node_total   <= '0;
      settle       <= '0;
      path_ready   <= 1'b0;
      path_input   <= 1'b0;
      path_planned <= '0;
      node_changed <= 1'b0;
      turn_valid   <= 1'b0;
      turn_cmd     <= '0;
      seg_idx      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state      <= COLLECT;
            wr         <= '0;
            rd         <= '0;
            seg_idx    <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            busy       <= 1'b1;
            path_ready <= 1'b1;
          end
        end
        COLLECT: begin
          if (path_valid) begin
            wr <= wr + PTR_W'(1);
            if (path_last) begin
              path_ready <= 1'b0;
              if (wr != '0) begin
                // buffer[0] was written on an earlier cycle, so it can be
                // presented together with the first path_input cycle.
                node_total   <= wr + PTR_W'(1);
                state        <= LOAD;
                path_input   <= 1'b1;
                path_planned <= buffer[0];
                rd           <= PTR_W'(1);
              end else begin
                state <= ERR;
                busy  <= 1'b0;
                error <= 1'b1;
              end
            end else if (wr == PTR_W'(MAX_NODES - 1)) begin
              path_ready <= 1'b0;
              state      <= ERR;
              busy       <= 1'b0;
              error      <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (rd == node_total) begin
            path_input <= 1'b0;
            state      <= WAIT_NODE;
          end else begin
            path_planned <= buffer[rd];
            rd           <= rd + PTR_W'(1);
          end
        end
        WAIT_NODE: begin
          if (node_rise) begin
            node_changed <= 1'b1;
            state        <= KICK;
          end
        end
        KICK: begin
          node_changed <= 1'b0;
          settle       <= '0;
          state        <= SETTLE;
        end
        SETTLE: begin
          if (settle == LAT_W'(TURN_LAT - 1)) begin
            turn_cmd   <= turn_flag;
            turn_valid <= 1'b1;
            state      <= ISSUE;
          end else begin
            settle <= settle + LAT_W'(1);
          end
        end
        ISSUE: begin
          if (turn_ready) begin
            turn_valid <= 1'b0;
            seg_idx    <= seg_nxt;
            if (PTR_W'(seg_nxt) == node_total - PTR_W'(1)) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= WAIT_NODE;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_path_sequencer.sv
// Scoreboard bench for path_sequencer: expected loaded nodes and turn codes
// are queued as stimulus is driven and popped as the DUT emits them.
module tb_path_sequencer;

  localparam int MAX_NODES = 6;
  localparam int TURN_LAT  = 8;

  logic       clk_3125KHz = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       path_valid = 1'b0;
  logic [4:0] path_node = '0;
  logic       path_last = 1'b0;
  logic       path_ready;
  logic       node_flag = 1'b0;
  logic [1:0] turn_flag = '0;
  logic       path_input;
  logic [4:0] path_planned;
  logic       node_changed;
  logic       turn_valid;
  logic [1:0] turn_cmd;
  logic       turn_ready = 1'b0;
  logic [2:0] seg_idx;
  logic       busy;
  logic       done;
  logic       error;

  path_sequencer #(.MAX_NODES(MAX_NODES), .TURN_LAT(TURN_LAT)) dut (
    .clk_3125KHz (clk_3125KHz),
    .rst_n       (rst_n),
    .start       (start),
    .path_valid  (path_valid),
    .path_node   (path_node),
    .path_last   (path_last),
    .path_ready  (path_ready),
    .node_flag   (node_flag),
    .turn_flag   (turn_flag),
    .path_input  (path_input),
    .path_planned(path_planned),
    .node_changed(node_changed),
    .turn_valid  (turn_valid),
    .turn_cmd    (turn_cmd),
    .turn_ready  (turn_ready),
    .seg_idx     (seg_idx),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #160 clk_3125KHz = ~clk_3125KHz;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int load_cnt = 0;
  int nc_cnt = 0;
  int nc_cyc = 0;
  logic tv_prev = 1'b0;
  logic [4:0] pq[$];
  logic [1:0] tq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(posedge clk_3125KHz) cyc <= cyc + 1;

  // Output monitor: pops scoreboard entries as the DUT produces them.
  always @(negedge clk_3125KHz) begin
    if (rst_n) begin
      if (path_input) begin
        load_cnt++;
        if (pq.size() == 0) chk("load_unexpected", 1, 0);
        else chk("path_planned", path_planned, pq.pop_front());
      end
      if (node_changed) begin
        nc_cnt++;
        nc_cyc = cyc;
      end
      if (turn_valid && !tv_prev) chk("turn_latency", cyc - nc_cyc, TURN_LAT + 1);
      if (turn_valid && turn_ready) begin
        if (tq.size() == 0) chk("turn_unexpected", 1, 0);
        else chk("turn_cmd", turn_cmd, tq.pop_front());
      end
    end
    tv_prev = turn_valid & rst_n;
  end

  task automatic tick();
    @(posedge clk_3125KHz);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_path(input logic [4:0] nodes[], input bit with_last, input bit expect_load);
    for (int i = 0; i < nodes.size(); i++) begin
      path_valid = 1'b1;
      path_node  = nodes[i];
      path_last  = with_last && (i == nodes.size() - 1);
      if (expect_load) pq.push_back(nodes[i]);
      tick();
    end
    path_valid = 1'b0;
    path_last  = 1'b0;
  endtask

  task automatic wait_load(input int n);
    for (int i = 0; i < 60 && load_cnt < n; i++) tick();
    tick();
    tick();
    chk("load_cycles", load_cnt, n);
    chk("load_ends", path_input, 0);
  endtask

  task automatic wait_tv();
    for (int i = 0; i < 100 && !turn_valid; i++) tick();
    chk("tv_arrives", turn_valid, 1);
  endtask

  task automatic segment(input logic [1:0] t, input int hold);
    int nc0;
    turn_flag = t;
    node_flag = 1'b1;
    tq.push_back(t);
    tick();
    tick();
    node_flag = 1'b0;
    wait_tv();
    nc0 = nc_cnt;
    for (int i = 0; i < hold; i++) begin
      if (i == 4 || i == 12) node_flag = 1'b1;
      if (i == 6 || i == 14) node_flag = 1'b0;
      turn_flag = ~t;
      tick();
      chk("tv_hold", turn_valid, 1);
      chk("cmd_hold", turn_cmd, t);
    end
    node_flag = 1'b0;
    if (hold > 0) chk("no_nc_in_issue", nc_cnt - nc0, 0);
    turn_ready = 1'b1;
    tick();
    turn_ready = 1'b0;
    turn_flag  = t;
  endtask

  initial begin
    logic [4:0] p_norm[]  = '{5'd0, 5'd1, 5'd2, 5'd8};
    logic [4:0] p_six[]   = '{5'd5, 5'd6, 5'd7, 5'd13, 5'd19, 5'd25};
    logic [4:0] p_ovf[]   = '{5'd3, 5'd4, 5'd9, 5'd10, 5'd11, 5'd12};
    logic [4:0] p_one[]   = '{5'd20};
    logic [4:0] p_three[] = '{5'd4, 5'd10, 5'd16};
    int nc0;

    // Reset state
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_ready", path_ready, 0);
    chk("rst_pin", path_input, 0);
    chk("rst_tv", turn_valid, 0);
    chk("rst_seg", seg_idx, 0);
    rst_n = 1'b1;
    tick();

    // Normal 4-node run
    do_start();
    chk("collect_ready", path_ready, 1);
    chk("collect_busy", busy, 1);
    load_cnt = 0;
    nc_cnt = 0;
    send_path(p_norm, 1'b1, 1'b1);
    wait_load(4);
    segment(2'd1, 0);
    segment(2'd2, 0);
    chk("mid_seg", seg_idx, 2);
    chk("mid_done", done, 0);
    segment(2'd3, 0);
    chk("norm_done", done, 1);
    chk("norm_seg", seg_idx, 3);
    chk("norm_busy", busy, 0);
    chk("norm_nc", nc_cnt, 3);

    // Overflow: six nodes without path_last
    do_start();
    chk("restart_done", done, 0);
    load_cnt = 0;
    send_path(p_ovf, 1'b0, 1'b0);
    chk("ovf_error", error, 1);
    chk("ovf_ready", path_ready, 0);
    chk("ovf_busy", busy, 0);
    do_start();
    chk("ovf_clear", error, 0);
    chk("ovf_collect", path_ready, 1);

    // Short path: one node with path_last
    send_path(p_one, 1'b1, 1'b0);
    chk("short_error", error, 1);
    tick();
    tick();
    chk("short_noload", load_cnt, 0);

    // Six-node boundary path with backpressure on one segment
    do_start();
    load_cnt = 0;
    nc_cnt = 0;
    send_path(p_six, 1'b1, 1'b1);
    wait_load(6);
    segment(2'd0, 0);
    segment(2'd2, 20);
    segment(2'd1, 0);
    segment(2'd3, 0);
    chk("six_not_done", done, 0);
    segment(2'd2, 0);
    chk("six_done", done, 1);
    chk("six_seg", seg_idx, 5);
    chk("six_nc", nc_cnt, 5);

    // Reset asserted during SETTLE
    do_start();
    load_cnt = 0;
    send_path(p_three, 1'b1, 1'b1);
    wait_load(3);
    nc0 = nc_cnt;
    turn_flag = 2'd2;
    node_flag = 1'b1;
    tick();
    tick();
    node_flag = 1'b0;
    for (int i = 0; i < 20 && nc_cnt == nc0; i++) tick();
    chk("rst_run_kick", nc_cnt - nc0, 1);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_tv", turn_valid, 0);
    chk("arst_seg", seg_idx, 0);
    tick();
    tick();
    rst_n = 1'b1;
    nc0 = nc_cnt;
    load_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      node_flag = (i % 6) < 3;
      tick();
    end
    node_flag = 1'b0;
    chk("post_rst_nc", nc_cnt - nc0, 0);
    chk("post_rst_load", load_cnt, 0);
    chk("post_rst_tv", turn_valid, 0);
    chk("post_rst_busy", busy, 0);

    chk("pq_empty", pq.size(), 0);
    chk("tq_empty", tq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
